round_ctrl: RTL and testbench

//  Round sequencer and input arbiter for the two-tank game. Splits the single USB keycode

---
 rtl/round_ctrl_if.sv | 28 ++
 rtl/round_ctrl.sv | 146 ++++++++++++++
 tb/tb_round_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/round_ctrl_if.sv
// Signal bundle between the round sequencer and its neighbours (keyboard, tanks, HUD).
// All signals are plain levels sampled every Clk cycle; there is no valid/ready handshake.
interface round_ctrl_if;
  logic       frame_clk;
  logic [7:0] keycode;
  logic       hit_p1;
  logic       hit_p2;
  logic [7:0] keycode_p1;
  logic [7:0] keycode_p2;
  logic       tank_reset;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [1:0] countdown;
  logic [2:0] state;
  logic [1:0] winner;

  modport master (
    output frame_clk, keycode, hit_p1, hit_p2,
    input  keycode_p1, keycode_p2, tank_reset, score_p1, score_p2,
    input  countdown, state, winner
  );

  modport slave (
    input  frame_clk, keycode, hit_p1, hit_p2,
    output keycode_p1, keycode_p2, tank_reset, score_p1, score_p2,
    output countdown, state, winner
  );
endinterface

// File: rtl/round_ctrl.sv
// Round sequencer and keyboard arbiter for the two-tank game: countdown, hit
// detection, scoring and winner; the state register doubles as the debug output.
module round_ctrl #(
  parameter logic [3:0] WIN_SCORE    = 4'd5,
  parameter logic [7:0] COUNT_FRAMES = 8'd60,
  parameter logic [7:0] HIT_FRAMES   = 8'd90
) (
  input logic        Clk,
  input logic        Reset_n,
  round_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_HIT       = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  state_t     state_q, state_nxt;
  logic [2:0] frame_sync;
  logic       tick;
  logic [7:0] frame_cnt, frame_nxt, frame_inc;
  logic [1:0] countdown_q, countdown_nxt;
  logic [3:0] score1_q, score1_nxt, score2_q, score2_nxt;
  logic [1:0] winner_q, winner_nxt;
  logic       armed_q, armed_nxt;
  logic [7:0] kp1_q, kp1_nxt, kp2_q, kp2_nxt;
  logic       tank_q, tank_nxt;
  logic       is_start, is_p1_key, is_p2_key;

  // Bits 0/1 synchronise the frame clock, bit 2 holds the previous level for edge detect.
  assign tick      = frame_sync[1] & ~frame_sync[2];
  assign frame_inc = frame_cnt + 8'd1;
  assign is_start  = (bus.keycode == 8'h2C) || (bus.keycode == 8'h28);
  assign is_p1_key = bus.keycode inside {8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C};
  assign is_p2_key = bus.keycode inside {8'h52, 8'h50, 8'h51, 8'h4F, 8'h28};

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      frame_sync  <= 3'b000;
      frame_cnt   <= 8'd0;
      countdown_q <= 2'd0;
      score1_q    <= 4'd0;
      score2_q    <= 4'd0;
      winner_q    <= 2'b00;
      armed_q     <= 1'b0;
      kp1_q       <= 8'h00;
      kp2_q       <= 8'h00;
      tank_q      <= 1'b1;
    end else begin
      state_q     <= state_nxt;
      frame_sync  <= {frame_sync[1:0], bus.frame_clk};
      frame_cnt   <= frame_nxt;
      countdown_q <= countdown_nxt;
      score1_q    <= score1_nxt;
      score2_q    <= score2_nxt;
      winner_q    <= winner_nxt;
      armed_q     <= armed_nxt;
      kp1_q       <= kp1_nxt;
      kp2_q       <= kp2_nxt;
      tank_q      <= tank_nxt;
    end
  end

  always_comb begin
    state_nxt     = state_q;
    frame_nxt     = tick ? frame_inc : frame_cnt;
    countdown_nxt = countdown_q;
    score1_nxt    = score1_q;
    score2_nxt    = score2_q;
    winner_nxt    = winner_q;

    case (state_q)
      S_IDLE: begin
        if (armed_q && is_start) begin
          state_nxt     = S_COUNTDOWN;
          countdown_nxt = 2'd3;
          score1_nxt    = 4'd0;
          score2_nxt    = 4'd0;
          winner_nxt    = 2'b00;
        end
      end
      S_COUNTDOWN: begin
        if (tick && frame_inc == COUNT_FRAMES) begin
          frame_nxt = 8'd0;
          if (countdown_q == 2'd1) begin
            state_nxt     = S_PLAY;
            countdown_nxt = 2'd0;
          end else begin
            countdown_nxt = countdown_q - 2'd1;
          end
        end
      end
      S_PLAY: begin
        if (bus.hit_p1 || bus.hit_p2) begin
          state_nxt = S_HIT;
          // A hit on tank 1 scores for player 2 and vice versa.
          if (bus.hit_p1 && score2_q != WIN_SCORE) score2_nxt = score2_q + 4'd1;
          if (bus.hit_p2 && score1_q != WIN_SCORE) score1_nxt = score1_q + 4'd1;
        end
      end
      S_HIT: begin
        if (tick && frame_inc == HIT_FRAMES) begin
          if (score1_q == WIN_SCORE || score2_q == WIN_SCORE) begin
            state_nxt  = S_GAME_OVER;
            winner_nxt = {score2_q == WIN_SCORE, score1_q == WIN_SCORE};
          end else begin
            state_nxt     = S_COUNTDOWN;
            countdown_nxt = 2'd3;
          end
        end
      end
      S_GAME_OVER: begin
        if (armed_q && is_start) state_nxt = S_IDLE;
      end
      default: begin
        state_nxt     = S_IDLE;
        countdown_nxt = 2'd0;
      end
    endcase

    if (state_nxt != state_q) frame_nxt = 8'd0;

    // A start key only counts after the key has been released inside the current state.
    if (state_nxt != state_q)    armed_nxt = 1'b0;
    else if (bus.keycode == 8'h00) armed_nxt = 1'b1;
    else                         armed_nxt = armed_q;

    kp1_nxt  = (state_nxt == S_PLAY && is_p1_key) ? bus.keycode : 8'h00;
    kp2_nxt  = (state_nxt == S_PLAY && is_p2_key) ? bus.keycode : 8'h00;
    tank_nxt = !(state_nxt == S_PLAY || state_nxt == S_HIT);
  end

  assign bus.state      = state_q;
  assign bus.countdown  = countdown_q;
  assign bus.score_p1   = score1_q;
  assign bus.score_p2   = score2_q;
  assign bus.winner     = winner_q;
  assign bus.keycode_p1 = kp1_q;
  assign bus.keycode_p2 = kp2_q;
  assign bus.tank_reset = tank_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Bench for round_ctrl: directed game sequences, a keycode routing table and a
// randomized event stream, all checked against a tick-level game model.
module tb_round_ctrl;
  localparam int WIN = 2;
  localparam int CF  = 2;
  localparam int HF  = 3;

  logic clk;
  logic rst_n;
  round_ctrl_if bus ();

  round_ctrl #(
    .WIN_SCORE(4'd2), .COUNT_FRAMES(8'd2), .HIT_FRAMES(8'd3)
  ) dut (
    .Clk(clk), .Reset_n(rst_n), .bus(bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- game model ----------------
  int         m_state, m_e, m_s1, m_s2, m_win;
  bit         m_armed;
  logic [7:0] m_key;

  function automatic void m_reset();
    m_state = 0; m_e = 0; m_s1 = 0; m_s2 = 0; m_win = 0; m_armed = 0;
  endfunction

  function automatic void m_enter(int s);
    m_state = s; m_e = 0; m_armed = 0;
  endfunction

  function automatic void m_settle();
    if (m_key == 8'h00) m_armed = 1;
  endfunction

  function automatic int m_cd();
    return (m_state == 1) ? 3 - m_e / CF : 0;
  endfunction

  function automatic logic [7:0] m_kp1();
    if (m_state == 2 && (m_key inside {8'h1A, 8'h04, 8'h16, 8'h07, 8'h2C})) return m_key;
    return 8'h00;
  endfunction

  function automatic logic [7:0] m_kp2();
    if (m_state == 2 && (m_key inside {8'h52, 8'h50, 8'h51, 8'h4F, 8'h28})) return m_key;
    return 8'h00;
  endfunction

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q[$];

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endfunction

  function automatic void check_all(string tag);
    chk({tag, " state"},      int'(bus.state),      m_state);
    chk({tag, " tank_reset"}, int'(bus.tank_reset), (m_state == 2 || m_state == 3) ? 0 : 1);
    chk({tag, " score_p1"},   int'(bus.score_p1),   m_s1);
    chk({tag, " score_p2"},   int'(bus.score_p2),   m_s2);
    chk({tag, " countdown"},  int'(bus.countdown),  m_cd());
    chk({tag, " winner"},     int'(bus.winner),     m_win);
    chk({tag, " keycode_p1"}, int'(bus.keycode_p1), int'(m_kp1()));
    chk({tag, " keycode_p2"}, int'(bus.keycode_p2), int'(m_kp2()));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_key(logic [7:0] k, string tag);
    bus.keycode = k;
    step(2);
    if (m_armed && (k == 8'h2C || k == 8'h28)) begin
      if (m_state == 0) begin
        m_enter(1); m_s1 = 0; m_s2 = 0; m_win = 0;
      end else if (m_state == 4) begin
        m_enter(0);
      end
    end
    m_key = k;
    m_settle();
    check_all(tag);
  endtask

  task automatic do_hit(bit h1, bit h2, string tag);
    bus.hit_p1 = h1;
    bus.hit_p2 = h2;
    step(1);
    bus.hit_p1 = 1'b0;
    bus.hit_p2 = 1'b0;
    step(2);
    if (m_state == 2 && (h1 || h2)) begin
      if (h1) m_s2 = (m_s2 + 1 > WIN) ? WIN : m_s2 + 1;
      if (h2) m_s1 = (m_s1 + 1 > WIN) ? WIN : m_s1 + 1;
      m_enter(3);
    end
    m_settle();
    check_all(tag);
  endtask

  task automatic do_tick(string tag);
    bus.frame_clk = 1'b1;
    step(4);
    bus.frame_clk = 1'b0;
    step(3);
    if (m_state == 1) begin
      m_e++;
      if (m_e == 3 * CF) m_enter(2);
    end else if (m_state == 3) begin
      m_e++;
      if (m_e == HF) begin
        if (m_s1 == WIN || m_s2 == WIN) begin
          m_enter(4);
          m_win = (m_s1 == WIN && m_s2 == WIN) ? 3 : (m_s1 == WIN ? 1 : 2);
        end else begin
          m_enter(1);
        end
      end
    end
    m_settle();
    check_all(tag);
  endtask

  task automatic do_async_reset(string tag);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_all({tag, " async"});
    chk({tag, " async state0"}, int'(bus.state), 0);
    chk({tag, " async tank1"},  int'(bus.tank_reset), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);
    m_settle();
    check_all({tag, " post"});
  endtask

  // ---------------- stimulus tables ----------------
  typedef struct {
    logic [7:0] key;
    logic [7:0] exp_p1;
    logic [7:0] exp_p2;
  } route_vec_t;

  route_vec_t route_tab[14];
  int         exp_cd[6];
  int         exp_st[6];

  initial begin
    route_tab = '{
      '{8'h1A, 8'h1A, 8'h00}, '{8'h04, 8'h04, 8'h00}, '{8'h16, 8'h16, 8'h00},
      '{8'h07, 8'h07, 8'h00}, '{8'h2C, 8'h2C, 8'h00}, '{8'h52, 8'h00, 8'h52},
      '{8'h50, 8'h00, 8'h50}, '{8'h51, 8'h00, 8'h51}, '{8'h4F, 8'h00, 8'h4F},
      '{8'h28, 8'h00, 8'h28}, '{8'h29, 8'h00, 8'h00}, '{8'h00, 8'h00, 8'h00},
      '{8'hFF, 8'h00, 8'h00}, '{8'h1B, 8'h00, 8'h00}
    };
    exp_cd = '{3, 2, 2, 1, 1, 0};
    exp_st = '{1, 1, 1, 1, 1, 2};

    rst_n = 1'b0;
    bus.frame_clk = 1'b0;
    bus.keycode = 8'h00;
    bus.hit_p1 = 1'b0;
    bus.hit_p2 = 1'b0;
    m_key = 8'h00;
    m_reset();

    // Reset values
    step(3);
    check_all("reset");
    chk("reset winner", int'(bus.winner), 0);
    rst_n = 1'b1;
    step(2);
    m_settle();

    // Start and countdown
    do_key(8'h00, "arm");
    do_key(8'h2C, "start");
    chk("start countdown3", int'(bus.countdown), 3);
    for (int i = 0; i < 6; i++) begin
      do_tick("cd tick");
      chk("cd value", int'(bus.countdown), exp_cd[i]);
      chk("cd state", int'(bus.state), exp_st[i]);
    end
    chk("play tank_reset", int'(bus.tank_reset), 0);

    // Keycode routing table
    foreach (route_tab[i]) begin
      exp_q.push_back({route_tab[i].exp_p1, route_tab[i].exp_p2});
      do_key(route_tab[i].key, "route model");
      chk("route table", int'({bus.keycode_p1, bus.keycode_p2}), int'(exp_q.pop_front()));
    end

    // Hit on tank 2, freeze, respawn
    do_key(8'h1A, "pre hit key");
    do_hit(1'b0, 1'b1, "hit p2");
    chk("hit score_p1", int'(bus.score_p1), 1);
    chk("hit state", int'(bus.state), 3);
    chk("hit kp1 gated", int'(bus.keycode_p1), 0);
    do_tick("hit t1");
    do_tick("hit t2");
    chk("hit hold", int'(bus.state), 3);
    do_tick("hit t3");
    chk("respawn state", int'(bus.state), 1);
    chk("respawn tank_reset", int'(bus.tank_reset), 1);

    // Reach 1-1, then simultaneous hits end the game in a draw
    repeat (6) do_tick("cd2");
    do_hit(1'b1, 1'b0, "hit p1");
    repeat (3) do_tick("hit2");
    repeat (6) do_tick("cd3");
    chk("one-all p1", int'(bus.score_p1), 1);
    chk("one-all p2", int'(bus.score_p2), 1);
    do_key(8'h2C, "hold start");
    do_hit(1'b1, 1'b1, "double hit");
    chk("double score_p1", int'(bus.score_p1), 2);
    chk("double score_p2", int'(bus.score_p2), 2);
    repeat (3) do_tick("final hit");
    chk("game over state", int'(bus.state), 4);
    chk("draw winner", int'(bus.winner), 3);
    do_tick("go idle tick");
    step(5);
    chk("start held stays", int'(bus.state), 4);
    do_key(8'h00, "go release");
    do_key(8'h28, "go restart");
    chk("back to idle", int'(bus.state), 0);

    // Async reset mid-countdown and mid-hit
    do_key(8'h00, "arm2");
    do_key(8'h2C, "start2");
    do_tick("cd mid");
    do_async_reset("rst cd");
    do_key(8'h00, "arm3");
    do_key(8'h2C, "start3");
    repeat (6) do_tick("cd4");
    do_hit(1'b1, 1'b0, "hit mid");
    do_tick("hit mid t");
    do_async_reset("rst hit");

    // Randomized event stream
    for (int n = 0; n < 400; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel <= 4) begin
        do_tick("rnd tick");
      end else if (sel <= 6) begin
        int h;
        h = $urandom_range(1, 3);
        do_hit(h[0], h[1], "rnd hit");
      end else begin
        logic [7:0] keys[8];
        keys = '{8'h00, 8'h2C, 8'h28, 8'h1A, 8'h52, 8'h29, 8'h04, 8'h50};
        do_key(keys[$urandom_range(0, 7)], "rnd key");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
